// File: rtl/bin_count_pkg.sv
// -----------------------------------------------------------------------------
// bin_count_pkg
// Shared definitions for the bin_count_updn counter family:
//   DIR_UP / DIR_DN   values of the 'up' direction input
//   DEFAULT_WIDTH     default counter width
//   MAX_WIDTH         widest counter the all_ones() helper can describe
//   all_ones(width)   the all-ones terminal value for a given width
// -----------------------------------------------------------------------------
package bin_count_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 64;

  // Built bit by bit so that width == MAX_WIDTH does not need an
  // out-of-range shift.
  function automatic logic [MAX_WIDTH-1:0] all_ones(input int width);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage : bin_count_pkg

// File: rtl/bin_count_tc.sv
// -----------------------------------------------------------------------------
// bin_count_tc
// Combinational terminal-count detector for bin_count_updn.
// at_term is high when the next enabled count in direction 'up' would wrap:
// dout == TOP when counting up, dout == 0 when counting down.
//
// Ports:
//   dout     in  [WIDTH]  current count
//   limit    in  [WIDTH]  programmable TOP (only with BIN_COUNT_LIMIT_EN)
//   up       in           direction (DIR_UP / DIR_DN)
//   at_term  out          terminal count reached
//
// Build option: BIN_COUNT_LIMIT_EN selects TOP = limit, otherwise TOP is
// all ones and the detect reduces to an AND / NOR of dout.
// -----------------------------------------------------------------------------
module bin_count_tc
  import bin_count_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] dout,
`ifdef BIN_COUNT_LIMIT_EN
  input  logic [WIDTH-1:0] limit,
`endif
  input  logic             up,
  output logic             at_term
);

`ifdef BIN_COUNT_LIMIT_EN
  assign at_term = (up == DIR_UP) ? (dout == limit) : (dout == '0);
`else
  assign at_term = (up == DIR_UP) ? (&dout) : ~(|dout);
`endif

endmodule : bin_count_tc

// File: rtl/bin_count_updn.sv
// -----------------------------------------------------------------------------
// bin_count_updn
// Parametrised up/down binary counter with parallel load, synchronous clear,
// cascade terminal count and a sticky wrap flag. Per-edge priority is
// clr > load > count > hold; arithmetic is modulo TOP+1.
//
// Ports:
//   clk    in            rising-edge clock
//   reset  in            asynchronous active-low reset
//   clr    in            synchronous clear of dout and wrap
//   load   in            synchronous parallel load of din
//   count  in            count enable
//   up     in            1 = increment, 0 = decrement
//   din    in  [WIDTH]   load value
//   limit  in  [WIDTH]   wrap limit (TOP), only with BIN_COUNT_LIMIT_EN
//   dout   out [WIDTH]   registered count
//   cout   out           terminal count, enable for the next cascade slice
//   wrap   out           sticky, set on any count wrap-around
//
// Build option: BIN_COUNT_LIMIT_EN adds the limit port and makes TOP = limit;
// without it TOP = 2**WIDTH - 1. WIDTH must be 1..MAX_WIDTH.
// -----------------------------------------------------------------------------
module bin_count_updn
  import bin_count_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic             count,
  input  logic             up,
  input  logic [WIDTH-1:0] din,
`ifdef BIN_COUNT_LIMIT_EN
  input  logic [WIDTH-1:0] limit,
`endif
  output logic [WIDTH-1:0] dout,
  output logic             cout,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] TOP_ALL = WIDTH'(all_ones(WIDTH));

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] top;
  logic             above_top;
  logic             at_term;

`ifdef BIN_COUNT_LIMIT_EN
  assign top       = limit;
  // A loaded value beyond the limit rolls to 0 on the next up-count.
  assign above_top = (dout_q > limit);
`else
  assign top       = TOP_ALL;
  assign above_top = 1'b0;
`endif

  bin_count_tc #(
    .WIDTH   (WIDTH)
  ) u_tc (
    .dout    (dout_q),
`ifdef BIN_COUNT_LIMIT_EN
    .limit   (limit),
`endif
    .up      (up),
    .at_term (at_term)
  );

  // Gated by reset so a held-low reset never enables a cascaded slice.
  assign cout = reset & ~clr & ~load & count & at_term;

  // NOTE: every output of this block gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    dout_d = dout_q;
    wrap_d = wrap_q;
    if (clr) begin
      dout_d = '0;
      wrap_d = 1'b0;
    end else if (load) begin
      dout_d = din;
    end else if (count) begin
      if (up == DIR_UP) begin
        if (at_term || above_top) begin
          dout_d = '0;
          wrap_d = 1'b1;
        end else begin
          dout_d = dout_q + WIDTH'(1);
        end
      end else begin
        if (at_term) begin
          dout_d = top;
          wrap_d = 1'b1;
        end else begin
          dout_d = dout_q - WIDTH'(1);
        end
      end
    end
  end

  // NOTE: non-blocking assignments keep every flop sampling the pre-edge
  // values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      wrap_q <= wrap_d;
    end
  end

  assign dout = dout_q;
  assign wrap = wrap_q;

endmodule : bin_count_updn
